// File: rtl/delay_scoreboard_32.sv
// Issue-side interlock for multi-cycle result producers: tracks in-flight destinations
// in a shift chain of latency slots, stalls on RAW/WAW/writeback-port hazards, emits one writeback per cycle.
module delay_scoreboard_32 #(
    parameter int NREGS = 32,
    parameter int REGW  = 5,
    parameter int LATW  = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             squashn,
    input  logic             issue_en,
    input  logic [REGW-1:0]  issue_dst,
    input  logic [LATW-1:0]  issue_lat,
    input  logic             src_a_en,
    input  logic [REGW-1:0]  src_a,
    input  logic             src_b_en,
    input  logic [REGW-1:0]  src_b,
    output logic             stalled,
    output logic             wb_en,
    output logic [REGW-1:0]  wb_dst,
    output logic [NREGS-1:0] busy_mask
);

    localparam int MAXLAT = (2 ** LATW) - 1;

    logic [MAXLAT:1]            slot_valid_r;
    logic [MAXLAT:1]            slot_valid_s;
    logic [MAXLAT:1][REGW-1:0]  slot_dst_r;
    logic [MAXLAT:1][REGW-1:0]  slot_dst_s;
    logic [NREGS-1:0]           busy_mask_r;
    logic [NREGS-1:0]           busy_mask_s;
    logic                       port_busy_s;
    logic                       stalled_s;
    logic                       acc_s;

    // r0 is never pending; slot[1] counts (no bypass of the writeback cycle)
    function automatic logic pending_f(
        input logic [REGW-1:0]           r,
        input logic [MAXLAT:1]           v,
        input logic [MAXLAT:1][REGW-1:0] d
    );
        logic hit;
        hit = 1'b0;
        for (int k = 1; k <= MAXLAT; k++) begin
            hit = hit | (v[k] & (d[k] == r));
        end
        return hit & (r != {REGW{1'b0}});
    endfunction

    // Hazard detection and issue acceptance
    always_comb begin
        port_busy_s = 1'b0;
        // slot[lat+1] shifts into slot[lat] on this edge, colliding with the new entry
        for (int k = 1; k < MAXLAT; k++) begin
            port_busy_s = port_busy_s | ((issue_lat == LATW'(k)) & slot_valid_r[k+1]);
        end
        stalled_s = issue_en & (
              (src_a_en & pending_f(src_a, slot_valid_r, slot_dst_r))
            | (src_b_en & pending_f(src_b, slot_valid_r, slot_dst_r))
            | ((|issue_dst) & pending_f(issue_dst, slot_valid_r, slot_dst_r))
            | ((|issue_dst) & (|issue_lat) & port_busy_s));
        acc_s = issue_en & ~stalled_s & squashn & (|issue_dst) & (|issue_lat);
    end

    // Next slot contents: shift toward slot[1], then insert the accepted issue
    always_comb begin
        slot_valid_s = {1'b0, slot_valid_r[MAXLAT:2]};
        slot_dst_s   = {{REGW{1'b0}}, slot_dst_r[MAXLAT:2]};
        for (int k = 1; k <= MAXLAT; k++) begin
            slot_valid_s[k] = slot_valid_s[k] | (acc_s & (issue_lat == LATW'(k)));
            slot_dst_s[k]   = (acc_s & (issue_lat == LATW'(k))) ? issue_dst : slot_dst_s[k];
        end
        busy_mask_s    = {NREGS{1'b0}};
        for (int r = 1; r < NREGS; r++) begin
            busy_mask_s[r] = pending_f(REGW'(r), slot_valid_s, slot_dst_s);
        end
    end

    // Slot chain and busy mask registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            slot_valid_r <= {MAXLAT{1'b0}};
            slot_dst_r   <= {(MAXLAT*REGW){1'b0}};
            busy_mask_r  <= {NREGS{1'b0}};
        end else begin
            slot_valid_r <= slot_valid_s;
            slot_dst_r   <= slot_dst_s;
            busy_mask_r  <= busy_mask_s;
        end
    end

    // Invalid slots always hold dst 0, so wb_dst is 0 whenever wb_en is low
    assign stalled   = stalled_s;
    assign wb_en     = slot_valid_r[1];
    assign wb_dst    = slot_dst_r[1];
    assign busy_mask = busy_mask_r;

endmodule

// File: tb/tb_delay_scoreboard_32.sv
// Self-checking bench for delay_scoreboard_32: directed scenarios plus random traffic
// compared against a list-of-in-flight-results reference model.
module tb_delay_scoreboard_32;

    logic        clk = 1'b0;
    logic        resetn, squashn, issue_en, src_a_en, src_b_en;
    logic [4:0]  issue_dst, src_a, src_b;
    logic [1:0]  issue_lat;
    logic        stalled, wb_en;
    logic [4:0]  wb_dst;
    logic [31:0] busy_mask;

    always #5 clk = ~clk;

    delay_scoreboard_32 dut (
        .clk(clk), .resetn(resetn), .squashn(squashn), .issue_en(issue_en),
        .issue_dst(issue_dst), .issue_lat(issue_lat),
        .src_a_en(src_a_en), .src_a(src_a), .src_b_en(src_b_en), .src_b(src_b),
        .stalled(stalled), .wb_en(wb_en), .wb_dst(wb_dst), .busy_mask(busy_mask)
    );

    // Model: each accepted issue is one record {dst, cycle its writeback is due}
    typedef struct {
        logic [4:0] dst;
        int         due;
    } ent_t;
    ent_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    function automatic bit m_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].dst == r && q[i].due >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_due_at(input int c);
        foreach (q[i]) if (q[i].due == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] m_wb_dst();
        foreach (q[i]) if (q[i].due == cyc) return q[i].dst;
        return 5'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic [4:0] dst, input logic [1:0] lat,
                        input logic sae, input logic [4:0] sa,
                        input logic sbe, input logic [4:0] sb,
                        input logic sq = 1'b1, input logic rn = 1'b1);
        bit          exp_stall;
        logic [31:0] exp_mask;
        issue_en = en; issue_dst = dst; issue_lat = lat;
        src_a_en = sae; src_a = sa; src_b_en = sbe; src_b = sb;
        squashn = sq; resetn = rn;
        #1;
        exp_stall = en && ((sae && m_pending(sa)) || (sbe && m_pending(sb))
                    || (dst != 5'd0 && m_pending(dst))
                    || (dst != 5'd0 && lat != 2'd0 && lat < 2'd3 && m_due_at(cyc + int'(lat))));
        exp_mask = 32'd0;
        for (int r = 1; r < 32; r++) exp_mask[r] = m_pending(5'(r));
        chk("stalled", 32'(stalled), 32'(exp_stall));
        chk("wb_en", 32'(wb_en), 32'(m_due_at(cyc)));
        chk("wb_dst", 32'(wb_dst), 32'(m_wb_dst()));
        chk("busy_mask", busy_mask, exp_mask);
        if (rn && en && !exp_stall && sq && dst != 5'd0 && lat != 2'd0)
            q.push_back('{dst: dst, due: cyc + int'(lat)});
        if (!rn) q.delete();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].due < cyc) q.delete(i);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        resetn = 1'b0; squashn = 1'b1; issue_en = 1'b0; issue_dst = 5'd0; issue_lat = 2'd0;
        src_a_en = 1'b0; src_a = 5'd0; src_b_en = 1'b0; src_b = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        // reset state
        idle(1);
        // T1: single lat-3 issue
        step(1'b1, 5'd5, 2'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        idle(4);
        // T2: RAW on r7 holds for two cycles, then clears
        step(1'b1, 5'd7, 2'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 5'd0, 2'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        step(1'b1, 5'd0, 2'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        step(1'b1, 5'd0, 2'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        idle(2);
        // T3: writeback-port conflicts
        step(1'b1, 5'd3, 2'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 5'd4, 2'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        idle(3);
        step(1'b1, 5'd3, 2'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 5'd4, 2'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        idle(4);
        // T4: r0 is never tracked
        step(1'b1, 5'd0, 2'd3, 1'b1, 5'd0, 1'b1, 5'd0);
        idle(4);
        // T5: squash does not touch earlier in-flight r6
        step(1'b1, 5'd6, 2'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 5'd9, 2'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(4);
        // T6: reset mid-flight drops r12
        step(1'b1, 5'd12, 2'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(3);
        // WAW with untracked latency still stalls
        step(1'b1, 5'd8, 2'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 5'd8, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        idle(4);
        // random traffic on a small register range to provoke hazards
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 63) != 0));
        end
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
